rx_cmd_packer: RTL
==================

# rx_cmd_packer

Receive-side endpoint for the control-channel response stream produced by the TX command reader. Accepts 16-bit response words on the `rx_databus`/`rx_WR`/`rx_WR_done` handshake and buffers one packet in a 256×16 RAM. It prepends the 4-word in-band header (length, control channel, timestamp), zero-pads to 512 bytes, and presents the packet to the FX2 read path. Sits between `cmd_reader` and the RX USB packet mux, in the `rxclk` domain.

## Interface
- `PKT_WORDS`, 256: packet size in 16-bit words, header included.
- `HDR_WORDS`, 4: header words at the start of each packet.
- `CTRL_CHAN`, 5'h1F: channel number written into header word 1.
- `rxclk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `adc_time` in 32: free-running sample timestamp.
- `rx_databus` in 16: response payload word.
- `rx_WR` in 1: write strobe, one payload word per cycle.
- `rx_WR_done` in 1: end-of-response strobe; seals the packet.
- `rx_WR_enabled` out 1: high when the block accepts writes.
- `pkt_ready` out 1: a sealed packet is waiting to be read.
- `RD` in 1: read strobe from the USB side, one word per cycle.
- `dataout` out 16: packet word, registered.
- `overrun` out 1: sticky flag; payload exceeded capacity.
- `clear_status` in 1: clears `overrun`.

## Operation
- States: IDLE, FILL, SEAL, READY, DRAIN.
- IDLE:
  - `rx_WR_enabled`=1, `wr_cnt`=0.
  - `rx_WR` writes `rx_databus` to address HDR_WORDS+`wr_cnt`, increments `wr_cnt`, goes to FILL.
  - When the timestamp feature is compiled in, the first `rx_WR` also captures `adc_time`.
- FILL:
  - `rx_WR_enabled`=1. Each `rx_WR` writes the next word.
  - Capacity is 252 payload words. Writes beyond capacity are discarded and set `overrun`; `wr_cnt` saturates at 252.
- `rx_WR_done` in IDLE or FILL goes to SEAL.
  - If `rx_WR` is asserted in the same cycle, that word is written first.
  - `rx_WR_done` in IDLE seals a 0-length packet.
- SEAL:
  - Writes header words 0..3 on four successive cycles, addresses 0..3.
  - Word 0 = {7'b0, len_bytes[8:0]}, where len_bytes = 2×`wr_cnt`.
  - Word 1 = {11'b0, CTRL_CHAN}.
  - Word 2 = timestamp[15:0]; word 3 = timestamp[31:16].
  - `rx_WR_enabled`=0. Goes to READY.
- READY: `pkt_ready`=1, `rx_WR_enabled`=0. The first `RD` goes to DRAIN.
- DRAIN:
  - Each `RD` advances `rd_addr` (0..255).
  - For addresses ≥ HDR_WORDS+`wr_cnt`, `dataout` is 16'h0000 (muxed, not read from RAM), so stale RAM contents never leak.
  - `pkt_ready` deasserts on the cycle after the first `RD`.
  - The cycle after the 256th `RD` returns to IDLE with `wr_cnt`=0.
- `RD` outside READY/DRAIN is ignored. `rx_WR`/`rx_WR_done` in SEAL/READY/DRAIN are ignored; the writer must respect `rx_WR_enabled`.
- `overrun` is set on any discarded write. It is cleared by `clear_status`; set takes priority if both occur in the same cycle.
- Reset mid-packet discards all buffered data. RAM contents need no reset.

## Timing
- Reset values:
  - `rx_WR_enabled`=1 (combinational from IDLE).
  - `pkt_ready`=0, `dataout`=0, `overrun`=0.
  - State IDLE, all counters 0.
- Write latency: a word is in RAM at the end of its `rx_WR` cycle.
- Seal latency: `pkt_ready` rises 5 cycles after the `rx_WR_done` cycle (1 transition + 4 header writes).
- Read latency: `dataout` carries word n one cycle after the n-th `RD` (1-cycle registered RAM). `RD` may be continuous or gapped; words hold between strobes.
- `rx_WR_enabled` falls combinationally in the cycle after `rx_WR_done`.

## Configuration
- `RX_CMD_TIMESTAMP_EN`:
  - Defined: `adc_time` is captured on the first payload write, or on `rx_WR_done` for 0-length packets, and written to header words 2/3.
  - Undefined: the capture register is removed and words 2/3 are 16'hFFFF (no-timestamp marker). `adc_time` is unused.

## Test plan
- Reset, then 3 writes 16'hA001..A003, `rx_WR_done`, with `adc_time`=32'h0001_0010 at the first write → 256 reads give 16'h0006, 16'h001F, 16'h0010, 16'h0001, A001, A002, A003, then 249 × 16'h0000; `pkt_ready` high 5 cycles after done.
- 260 writes then done → length word 16'h01F8; payload is words 0..251; `overrun`=1; `clear_status` clears it.
- `rx_WR` and `rx_WR_done` in the same cycle with data 16'hBEEF → that word appears as payload 0; length 16'h0002.
- `rx_WR_done` alone from IDLE → length 16'h0000, words 4..255 all zero.
- Gapped `RD` (every 3rd cycle) → `dataout` holds between strobes and the sequence is correct; `rx_WR_enabled` returns to 1 only after the 256th read.
- `reset_n` low during DRAIN at read 100 → outputs return to reset values immediately, and the next packet reads back correctly with no stale payload.
- Build without `RX_CMD_TIMESTAMP_EN` → words 2/3 are 16'hFFFF for every packet.

Source files
------------

// File: rtl/rx_cmd_packer.sv
// rtl/rx_cmd_packer.sv - control-channel response packer: one 256x16 packet with in-band header, zero-padded
// Define RX_CMD_TIMESTAMP_EN to stamp adc_time into header words 2/3; otherwise they carry 16'hFFFF.
module rx_cmd_packer #(
   parameter int         PKT_WORDS = 256,
   parameter int         HDR_WORDS = 4,
   parameter logic [4:0] CTRL_CHAN = 5'h1F
) (
   input  logic        rxclk,
   input  logic        reset_n,
   input  logic [31:0] adc_time,
   input  logic [15:0] rx_databus,
   input  logic        rx_WR,
   input  logic        rx_WR_done,
   output logic        rx_WR_enabled,
   output logic        pkt_ready,
   input  logic        RD,
   output logic [15:0] dataout,
   output logic        overrun,
   input  logic        clear_status
);
   localparam int            AW        = $clog2(PKT_WORDS);
   localparam logic [AW-1:0] CAP       = AW'(PKT_WORDS - HDR_WORDS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(PKT_WORDS - 1);
   localparam logic [AW:0]   HDR_OFS   = (AW+1)'(HDR_WORDS);

   typedef enum logic [2:0] {IDLE, FILL, SEAL, READY, DRAIN} state_t;

   state_t        state;
   logic [AW-1:0] wr_cnt;
   logic [AW-1:0] rd_addr;
   logic [1:0]    seal_idx;
   logic [31:0]   ts;

   logic [15:0]   ram [PKT_WORDS];
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [15:0]   ram_wdata;
   logic [15:0]   hdr_word;

   logic          accepting;
   logic          wr_take;
   logic          wr_discard;
   logic          rd_take;
   logic          in_payload;
   logic [15:0]   rd_word;

   assign accepting     = (state == IDLE) || (state == FILL);
   assign rx_WR_enabled = accepting;
   assign wr_take       = accepting && rx_WR && (wr_cnt != CAP);
   assign wr_discard    = accepting && rx_WR && (wr_cnt == CAP);
   assign rd_take       = RD && ((state == READY) || (state == DRAIN));

   // Anything past the sealed payload reads as zero so a previous, longer packet never leaks out.
   assign in_payload = {1'b0, rd_addr} < (HDR_OFS + {1'b0, wr_cnt});
   assign rd_word    = in_payload ? ram[rd_addr] : 16'h0000;

`ifdef RX_CMD_TIMESTAMP_EN
   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         ts <= '0;
      end else if ((state == IDLE) && (rx_WR || rx_WR_done)) begin
         ts <= adc_time;
      end
   end
`else
   logic unused_adc_time;
   assign unused_adc_time = ^adc_time;
   assign ts              = 32'hFFFF_FFFF;
`endif

   always_comb begin
      hdr_word = 16'h0000;
      case (seal_idx)
         2'd0:    hdr_word = 16'({wr_cnt, 1'b0});
         2'd1:    hdr_word = {11'b0, CTRL_CHAN};
         2'd2:    hdr_word = ts[15:0];
         default: hdr_word = ts[31:16];
      endcase
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = '0;
      ram_wdata = rx_databus;
      if (wr_take) begin
         ram_we    = 1'b1;
         ram_waddr = HDR_OFS[AW-1:0] + wr_cnt;
      end else if (state == SEAL) begin
         ram_we    = 1'b1;
         ram_waddr = AW'(seal_idx);
         ram_wdata = hdr_word;
      end
   end

   always_ff @(posedge rxclk) begin
      if (ram_we) begin
         ram[ram_waddr] <= ram_wdata;
      end
   end

   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wr_cnt    <= '0;
         rd_addr   <= '0;
         seal_idx  <= 2'd0;
         pkt_ready <= 1'b0;
         dataout   <= 16'h0000;
         overrun   <= 1'b0;
      end else begin
         if (wr_discard) begin
            overrun <= 1'b1;
         end else if (clear_status) begin
            overrun <= 1'b0;
         end

         if (wr_take) begin
            wr_cnt <= wr_cnt + 1'b1;
         end

         if (rd_take) begin
            dataout <= rd_word;
            rd_addr <= rd_addr + 1'b1;
         end

         case (state)
            IDLE, FILL: begin
               if (rx_WR_done) begin
                  state <= SEAL;
               end else if (rx_WR) begin
                  state <= FILL;
               end
            end
            SEAL: begin
               seal_idx <= seal_idx + 1'b1;
               if (seal_idx == 2'd3) begin
                  state     <= READY;
                  pkt_ready <= 1'b1;
               end
            end
            READY: begin
               if (RD) begin
                  pkt_ready <= 1'b0;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (RD && (rd_addr == LAST_ADDR)) begin
                  state   <= IDLE;
                  wr_cnt  <= '0;
                  rd_addr <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
